// File: rtl/multiword_add_seq_pkg.sv
// Shared constants, FSM state type and index-width helpers for the multiword sequential adder.
package add_pkg;

   localparam int LIMB_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

   // A single-limb build still needs a one-bit index register.
   function automatic int idx_width(input int words);
      return (words > 1) ? clog2(words) : 1;
   endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq; ovf exists only with OVERFLOW_FLAG_EN.
interface multiword_add_seq_if #(
   parameter int WORDS = 4
);
   localparam int N = add_pkg::LIMB_W * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef OVERFLOW_FLAG_EN
   logic         ovf;
`endif

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
`ifdef OVERFLOW_FLAG_EN
      , output ovf
`endif
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
`ifdef OVERFLOW_FLAG_EN
      , input ovf
`endif
   );

endinterface

// File: rtl/multiword_add_seq_add16_slice.sv
// Combinational 16-bit carry-select adder slice: low byte ripples, high byte is precomputed for both carries.
module add16_slice
   import add_pkg::*;
(
   input  logic [LIMB_W-1:0] x_i,
   input  logic [LIMB_W-1:0] y_i,
   input  logic              ci_i,
   output logic [LIMB_W-1:0] s_o,
   output logic              co_o
);

   logic [8:0] lo_sum;
   logic [8:0] hi_sum0;
   logic [8:0] hi_sum1;

   always_comb begin
      lo_sum  = {1'b0, x_i[7:0]}  + {1'b0, y_i[7:0]}  + {8'd0, ci_i};
      hi_sum0 = {1'b0, x_i[15:8]} + {1'b0, y_i[15:8]};
      hi_sum1 = {1'b0, x_i[15:8]} + {1'b0, y_i[15:8]} + 9'd1;
      if (lo_sum[8]) begin
         s_o  = {hi_sum1[7:0], lo_sum[7:0]};
         co_o = hi_sum1[8];
      end else begin
         s_o  = {hi_sum0[7:0], lo_sum[7:0]};
         co_o = hi_sum0[8];
      end
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential WORDS*16-bit adder, one limb per clock through a shared add16_slice.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module multiword_add_seq
   import add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   multiword_add_seq_if.slave  bus
);

   localparam int N     = LIMB_W * WORDS;
   localparam int IDX_W = idx_width(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [LIMB_W-1:0] slice_x;
   logic [LIMB_W-1:0] slice_y;
   logic [LIMB_W-1:0] slice_s;
   logic              slice_co;

   assign slice_x = a_q[idx_q*LIMB_W +: LIMB_W];
   assign slice_y = b_q[idx_q*LIMB_W +: LIMB_W];

   add16_slice u_slice (
      .x_i  (slice_x),
      .y_i  (slice_y),
      .ci_i (carry_q),
      .s_o  (slice_s),
      .co_o (slice_co)
   );

`ifdef OVERFLOW_FLAG_EN
   logic ovf_q, ovf_d;
   // Carry into the MSB is recovered from the top limb's sum bit and operand bits.
   logic msb_carry_in;
   assign msb_carry_in = slice_s[LIMB_W-1] ^ slice_x[LIMB_W-1] ^ slice_y[LIMB_W-1];
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*LIMB_W +: LIMB_W] = slice_s;
            carry_d = slice_co;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_co;
`ifdef OVERFLOW_FLAG_EN
               ovf_d   = msb_carry_in ^ slice_co;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

`ifdef OVERFLOW_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end
   assign bus.ovf = ovf_q;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4) against a wide-arithmetic transaction model.
module tb_multiword_add_seq;

   localparam int WORDS = 4;
   localparam int N     = 16 * WORDS;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   bit   chk_en;

   multiword_add_seq_if #(.WORDS(WORDS)) bus ();

   multiword_add_seq #(.WORDS(WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: an operation is in flight from its accepting edge until the edge that takes
   // the result; the result is presented once WORDS edges have passed since acceptance.
   bit           m_active;
   int           m_cnt;
   logic [N-1:0] m_sum;
   logic         m_cout;
   logic         m_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_cnt    = 0;
      end else if (!m_active) begin
         if (bus.in_valid) begin
            logic [N:0] wide;
            wide     = {1'b0, bus.a} + {1'b0, bus.b} + (N+1)'(bus.cin);
            m_sum    = wide[N-1:0];
            m_cout   = wide[N];
            m_ovf    = (m_sum[N-1] ^ bus.a[N-1] ^ bus.b[N-1]) ^ m_cout;
            m_active = 1'b1;
            m_cnt    = 0;
         end
      end else if (m_cnt < WORDS) begin
         m_cnt++;
      end else if (bus.out_ready) begin
         m_active = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("in_ready", (N+1)'(bus.in_ready), (N+1)'(!m_active));
         chk("busy", (N+1)'(bus.busy), (N+1)'(m_active));
         chk("out_valid", (N+1)'(bus.out_valid), (N+1)'(m_active && m_cnt == WORDS));
         if (m_active && m_cnt == WORDS) begin
            chk("sum", (N+1)'(bus.sum), (N+1)'(m_sum));
            chk("cout", (N+1)'(bus.cout), (N+1)'(m_cout));
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", (N+1)'(bus.ovf), (N+1)'(m_ovf));
`endif
         end
      end
   end

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      @(posedge clk); #2;
      bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.out_valid && n < 20);
      if (!bus.out_valid) chk("timeout", 0, 1);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(posedge clk); #2;
      bus.out_ready = 1'b0;
   endtask

   task automatic literal_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic c, input logic [N-1:0] es, input logic ec);
      int n;
      start_op(a, b, c);
      wait_done(n);
      chk({name, "_latency"}, (N+1)'(n), (N+1)'(WORDS));
      chk({name, "_sum"}, (N+1)'(bus.sum), (N+1)'(es));
      chk({name, "_cout"}, (N+1)'(bus.cout), (N+1)'(ec));
      chk({name, "_model"}, {m_cout, m_sum}, {ec, es});
      release_result();
   endtask

   initial begin
      int n;
      tests = 0; fails = 0; chk_en = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", (N+1)'(bus.in_ready), 1);
      chk("rst_out_valid", (N+1)'(bus.out_valid), 0);
      chk("rst_busy", (N+1)'(bus.busy), 0);
      chk("rst_sum", (N+1)'(bus.sum), 0);
      chk("rst_cout", (N+1)'(bus.cout), 0);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      literal_op("c1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
      literal_op("c2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
      literal_op("c3", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                 64'h2222_2222_2222_2212, 1'b0);

      // Result held in DONE while new requests are offered and ignored.
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      wait_done(n);
      for (int k = 0; k < 10; k++) begin
         bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
         bus.cin = 1'($urandom); bus.in_valid = 1'b1;
         @(posedge clk); #1;
         chk("hold_in_ready", (N+1)'(bus.in_ready), 0);
         chk("hold_out_valid", (N+1)'(bus.out_valid), 1);
         chk("hold_sum", (N+1)'(bus.sum), 0);
         chk("hold_cout", (N+1)'(bus.cout), 1);
      end
      // Taking the result with in_valid high must not accept on the same edge.
      bus.a = 64'h1234_5678_9ABC_DEF0; bus.b = 64'h0FED_CBA9_8765_4321; bus.cin = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("take_in_ready", (N+1)'(bus.in_ready), 1);
      chk("take_out_valid", (N+1)'(bus.out_valid), 0);
      bus.out_ready = 1'b0;
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      wait_done(n);
      chk("after_take_latency", (N+1)'(n), (N+1)'(WORDS));
      chk("after_take_sum", (N+1)'(bus.sum), (N+1)'(64'h2222_2222_2222_2212));
      release_result();

      // Abort two limbs into RUN.
      start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_out_valid", (N+1)'(bus.out_valid), 0);
      chk("abort_busy", (N+1)'(bus.busy), 0);
      chk("abort_sum", (N+1)'(bus.sum), 0);
      chk("abort_cout", (N+1)'(bus.cout), 0);
      chk("abort_in_ready", (N+1)'(bus.in_ready), 1);
      @(posedge clk); #2;
      rst = 1'b0;
      literal_op("c5", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);

      literal_op("c6", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
`ifdef OVERFLOW_FLAG_EN
      chk("c6_model_ovf", (N+1)'(m_ovf), 1);
`endif

      // Randomized traffic with junk requests during RUN/DONE and random result back-pressure.
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] ra, rb;
         int hold;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) ra = '1;
         if ($urandom_range(0, 5) == 0) rb = (i % 2 == 0) ? '0 : '1;
         start_op(ra, rb, 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
            bus.cin = 1'($urandom); bus.in_valid = 1'b1;
         end
         wait_done(n);
         chk("rand_latency", (N+1)'(n), (N+1)'(WORDS));
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b0;
         release_result();
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
